// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU port, debug/loader port and RAM side signals
// for the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_wren;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_q;

    logic              d_req;
    logic              d_wren;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_q;

    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    logic [3:0]        wait_cnt;

    modport slave (
        input  c_req, c_wren, c_addr, c_data,
        output c_gnt, c_stall, c_rvalid, c_q,
        input  d_req, d_wren, d_addr, d_data,
        output d_gnt, d_rvalid, d_q,
        output ram_wEn, ram_addr, ram_dataIn,
        input  ram_dataOut,
        output wait_cnt
    );

    modport master (
        output c_req, c_wren, c_addr, c_data,
        input  c_gnt, c_stall, c_rvalid, c_q,
        output d_req, d_wren, d_addr, d_data,
        input  d_gnt, d_rvalid, d_q,
        input  ram_wEn, ram_addr, ram_dataIn,
        output ram_dataOut,
        input  wait_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU and the debug port.
// CPU has priority; the debug port gets a boosted grant after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic       c_rv_q, c_rv_d;
    logic       d_rv_q, d_rv_d;
    logic       own_q, own_d;
    logic [3:0] wait_q, wait_d;
    logic       boost;
    logic       c_gnt, d_gnt;

    // Grant decision: CPU first, unless the debug port has waited too long
    always_comb begin
        boost = (wait_q >= MaxWait);
        d_gnt = 1'b0;
        c_gnt = 1'b0;
        if (!reset) begin
            d_gnt = bus.d_req & (boost | ~bus.c_req);
            c_gnt = bus.c_req & ~d_gnt;
        end
    end

    // RAM mux, handshake outputs and read return
    always_comb begin
        bus.c_gnt      = c_gnt;
        bus.d_gnt      = d_gnt;
        bus.c_stall    = bus.c_req & ~c_gnt;
        bus.ram_addr   = d_gnt ? bus.d_addr : bus.c_addr;
        bus.ram_dataIn = d_gnt ? bus.d_data : bus.c_data;
        bus.ram_wEn    = d_gnt ? bus.d_wren : (c_gnt & bus.c_wren);
        bus.c_rvalid   = c_rv_q & ~own_q & ~reset;
        bus.d_rvalid   = d_rv_q & own_q & ~reset;
        bus.c_q        = bus.ram_dataOut;
        bus.d_q        = bus.ram_dataOut;
        bus.wait_cnt   = wait_q;
    end

    // Next state: read-valid pipeline, owner and starvation counter
    always_comb begin
        c_rv_d = c_gnt & ~bus.c_wren;
        d_rv_d = d_gnt & ~bus.d_wren;
        own_d  = own_q;
        wait_d = 4'd0;
        if (d_gnt) begin
            own_d = 1'b1;
        end else if (c_gnt) begin
            own_d = 1'b0;
        end
        if (bus.d_req && !d_gnt) begin
            wait_d = (wait_q == 4'd15) ? wait_q : wait_q + 4'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            c_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
            own_q  <= 1'b0;
            wait_q <= 4'd0;
        end else begin
            c_rv_q <= c_rv_d;
            d_rv_q <= d_rv_d;
            own_q  <= own_d;
            wait_q <= wait_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural
// synchronous-read RAM attached to the RAM side.
module tb_dmem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   fails;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:4095];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: write and registered read at posedge
    always @(posedge clk) begin
        if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
        bus.ram_dataOut <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge; inputs are driven there and
    // outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic cset(input logic r, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
        bus.c_req = r; bus.c_wren = w; bus.c_addr = a; bus.c_data = d;
    endtask

    task automatic dset(input logic r, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
        bus.d_req = r; bus.d_wren = w; bus.d_addr = a; bus.d_data = d;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h7FF] = 32'hDEADBEEF;

        // Reset held two cycles with both ports requesting
        reset = 1'b1;
        cset(1'b1, 1'b0, 12'h0, 32'h0);
        dset(1'b1, 1'b0, 12'h1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        chk("rst_wEn", 32'(bus.ram_wEn), 32'd0);
        chk("rst_wait", 32'(bus.wait_cnt), 32'd0);
        chk("rst_c_rv", 32'(bus.c_rvalid), 32'd0);
        chk("rst_d_rv", 32'(bus.d_rvalid), 32'd0);
        chk("rst_stall", 32'(bus.c_stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rel_c_gnt", 32'(bus.c_gnt), 32'd1);
        chk("rel_d_gnt", 32'(bus.d_gnt), 32'd0);

        // CPU write then read of addr 5
        step();
        cset(1'b1, 1'b1, 12'd5, 32'h0000_00AB);
        dset(1'b0, 1'b0, 12'd0, 32'h0);
        #1;
        chk("cw_gnt", 32'(bus.c_gnt), 32'd1);
        chk("cw_wEn", 32'(bus.ram_wEn), 32'd1);
        chk("cw_addr", 32'(bus.ram_addr), 32'd5);
        step();
        cset(1'b1, 1'b0, 12'd5, 32'h0);
        #1;
        chk("cr_gnt", 32'(bus.c_gnt), 32'd1);
        chk("cr_wEn", 32'(bus.ram_wEn), 32'd0);
        step();
        cset(1'b0, 1'b0, 12'd0, 32'h0);
        #1;
        chk("cr_rv", 32'(bus.c_rvalid), 32'd1);
        chk("cr_q", bus.c_q, 32'h0000_00AB);
        chk("cr_d_rv", 32'(bus.d_rvalid), 32'd0);

        // Debug-only read of the preloaded word
        step();
        dset(1'b1, 1'b0, 12'h7FF, 32'h0);
        #1;
        chk("dr_gnt", 32'(bus.d_gnt), 32'd1);
        chk("dr_stall", 32'(bus.c_stall), 32'd0);
        chk("dr_addr", 32'(bus.ram_addr), 32'h7FF);
        step();
        dset(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("dr_rv", 32'(bus.d_rvalid), 32'd1);
        chk("dr_q", bus.d_q, 32'hDEADBEEF);
        chk("dr_c_rv", 32'(bus.c_rvalid), 32'd0);

        // Contention: period-5 pattern with MAX_WAIT = 4
        step();
        cset(1'b1, 1'b0, 12'd0, 32'h0);
        dset(1'b1, 1'b0, 12'd1, 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("pat_wait", 32'(bus.wait_cnt), 32'(k % 5));
            chk("pat_c_gnt", 32'(bus.c_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
            chk("pat_d_gnt", 32'(bus.d_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("pat_stall", 32'(bus.c_stall), (k % 5 == 4) ? 32'd1 : 32'd0);
            step();
        end
        cset(1'b0, 1'b0, 12'd0, 32'h0);
        dset(1'b0, 1'b0, 12'd0, 32'h0);

        // Debug write wins at wait_cnt == 4; CPU reads the new word
        step();
        cset(1'b1, 1'b0, 12'd9, 32'h0);
        dset(1'b1, 1'b1, 12'd9, 32'h0000_1234);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bw_c_gnt", 32'(bus.c_gnt), 32'd1);
            step();
        end
        #1;
        chk("bw_wait", 32'(bus.wait_cnt), 32'd4);
        chk("bw_d_gnt", 32'(bus.d_gnt), 32'd1);
        chk("bw_wEn", 32'(bus.ram_wEn), 32'd1);
        chk("bw_stall", 32'(bus.c_stall), 32'd1);
        step();
        dset(1'b0, 1'b0, 12'd0, 32'h0);
        #1;
        chk("bw_c_gnt2", 32'(bus.c_gnt), 32'd1);
        chk("bw_wait0", 32'(bus.wait_cnt), 32'd0);
        step();
        cset(1'b0, 1'b0, 12'd0, 32'h0);
        #1;
        chk("bw_c_rv", 32'(bus.c_rvalid), 32'd1);
        chk("bw_c_q", bus.c_q, 32'h0000_1234);
        chk("bw_d_rv", 32'(bus.d_rvalid), 32'd0);

        // CPU read granted, reset asserted next cycle
        step();
        cset(1'b1, 1'b0, 12'd5, 32'h0);
        #1;
        chk("rr_gnt", 32'(bus.c_gnt), 32'd1);
        step();
        cset(1'b0, 1'b0, 12'd0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rr_rv_rst", 32'(bus.c_rvalid), 32'd0);
        chk("rr_gnt_rst", 32'(bus.c_gnt), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rr_rv_rel", 32'(bus.c_rvalid), 32'd0);
        chk("rr_drv_rel", 32'(bus.d_rvalid), 32'd0);
        step();
        #1;
        chk("rr_rv_rel2", 32'(bus.c_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (12-bit address, 32-bit word, synchronous read) between two requesters: the processor's dmem port (port C) and a debug/loader port (port D).
- The debug/loader port preloads or inspects memory while the CPU runs.
- Sits between processor and RAM in the Wrapper.
- Fixed CPU priority with a bounded-wait starvation guard for port D; one grant per cycle, fully pipelined, read data returned one cycle after grant.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, RAM data width.
- MAX_WAIT, 4, consecutive denied cycles after which port D wins priority for one grant (legal range 1..15).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  CPU access request (held until c_gnt).
- c_wren  in  1  CPU write enable (1 = write, 0 = read).
- c_addr  in  ADDR_W  CPU word address.
- c_data  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU access accepted this cycle (combinational).
- c_stall  out  1  c_req & ~c_gnt; to processor pipeline stall.
- c_rvalid  out  1  CPU read data valid on c_q this cycle.
- c_q  out  DATA_W  CPU read data.
- d_req, d_wren, d_addr, d_data  in  same widths as the c_* inputs; debug/loader request.
- d_gnt  out  1  debug access accepted this cycle.
- d_rvalid  out  1  debug read data valid.
- d_q  out  DATA_W  debug read data.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_dataIn  out  DATA_W  RAM write data.
- ram_dataOut  in  DATA_W  RAM read data (registered inside RAM, valid the cycle after address).
- wait_cnt  out  4  current port-D denied-cycle count (debug visibility).

Behaviour:
- Reset, synchronous, checked at posedge:
  - wait_cnt = 0, c_rvalid = d_rvalid = 0, owner register = C.
  - While reset is high: c_gnt = d_gnt = 0 and ram_wEn = 0; c_stall follows c_req.
- Arbitration (combinational, each cycle, reset low):
  - boost = (wait_cnt >= MAX_WAIT).
  - d_req & (boost | ~c_req) -> d_gnt = 1, c_gnt = 0.
  - else c_req -> c_gnt = 1.
  - neither -> no grant, ram_wEn = 0, ram_addr/ram_dataIn hold the C port values.
- RAM drive: ram_addr/ram_dataIn/ram_wEn are muxed from the granted port; ram_wEn = granted port's wren & gnt. A write completes at the posedge of the grant cycle.
- Read return, latency 1:
  - At posedge, x_rvalid <= x_gnt & ~x_wren, and owner <= granted port.
  - In cycle t+1, c_q = d_q = ram_dataOut; only the owner's rvalid is high.
  - Back-to-back reads every cycle are allowed; throughput is 1 access per cycle.
- Starvation counter (posedge):
  - d_req & ~d_gnt -> wait_cnt + 1, saturating at 15.
  - d_gnt or ~d_req -> wait_cnt = 0.
- Simultaneous events:
  - Both requesting, wait_cnt < MAX_WAIT: C wins.
  - Both requesting at wait_cnt == MAX_WAIT: D wins, C stalls exactly one cycle.
- Reset mid-operation: a read granted the cycle before reset still has rvalid forced to 0 (reset priority); in-flight data is discarded.
- Same-address write then read by either port in consecutive cycles returns the new data; the RAM write precedes the next read.
- No combinational path from ram_dataOut to any grant.

Test Plan:
- Reset held 2 cycles with c_req = d_req = 1 -> c_gnt = d_gnt = 0, ram_wEn = 0, wait_cnt = 0, rvalids 0; first cycle after release c_gnt = 1.
- CPU writes 0x0000_00AB to addr 5, then reads addr 5 next cycle -> ram_wEn = 1 in cycle 0; c_rvalid = 1 with c_q = 0x0000_00AB in cycle 2; d_rvalid stays 0.
- Debug only: d_req read addr 0x7FF (preloaded 0xDEADBEEF) -> d_gnt same cycle, d_rvalid = 1 and d_q = 0xDEADBEEF next cycle, c_stall = 0.
- Continuous c_req reads plus continuous d_req, MAX_WAIT = 4 -> c_gnt for 4 cycles with wait_cnt 1,2,3,4, then d_gnt one cycle (c_stall = 1), wait_cnt back to 0; pattern repeats with period 5.
- Debug writes 0x1234 to addr 9 in the same cycle CPU requests a read of addr 9 at wait_cnt = 4 -> D granted, CPU granted next cycle, c_q = 0x1234 one cycle later.
- CPU read granted, reset asserted the following cycle -> c_rvalid = 0 during reset; no stale rvalid after release.
